apb_master_bridge: RTL and testbench

Single-slave APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers. It drives PSELx/PENABLE/PADDR/PWRITE/PWDATA toward the APB register-file slave, waits out slave wait states, captures PRDATA, and returns a one-cycle response pulse. A programmable wait-state timeout guarantees forward progress when PREADY never arrives. It is the initiator side of the APB link used by the register-file subsystem.

---
 rtl/apb_master_bridge.sv | 100 ++++++++++
 tb/tb_apb_master_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-slave APB requester: command handshake -> SETUP -> ACCESS (+wait states) -> one-cycle response pulse.
// Latency 2 cycles + slave wait states; cmd_ready low while busy, and responses are not backpressured.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    localparam int CW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LIMIT_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == LIMIT);
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state  <= SETUP;
                        PSELx  <= 1'b1;
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    // A ready on the limit cycle still wins over the abort.
                    if (PREADY) begin
                        state     <= IDLE;
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSELx   <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, hand sequences, and randomized transfers vs a reference model.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        PSELx, PENABLE, PWRITE, PREADY;
    logic [15:0] PADDR;
    logic [31:0] PWDATA, PRDATA;

    apb_master_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_log[$];

    // Register-file slave: wait_n wait states per transfer (-1 = never ready), or ready tied high.
    logic [31:0] slv_mem [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    int acc_cnt = 0;
    int wait_n  = 0;
    bit ready_tied = 1'b0;

    assign PREADY = ready_tied || (PSELx && PENABLE && (acc_cnt == wait_n));
    assign PRDATA = (PSELx && PENABLE && PREADY) ? slv_mem[PADDR[9:2]] : (32'hBAD0_0000 ^ 32'(acc_cnt));

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready && !PRESET) hs_log.push_back(cyc + 1);
        acc_cnt <= (PSELx && PENABLE) ? acc_cnt + 1 : 0;
        if (PSELx && PENABLE && PREADY && PWRITE) slv_mem[PADDR[9:2]] <= PWDATA;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] d, input int w,
                        input bit tied, output int lat, output bit err, output logic [31:0] rd,
                        output int nsel, output int nen, output bit stable_ok, output bit to);
        int h;
        wait_n = w;
        ready_tied = tied;
        to = 1'b0; lat = -1; err = 1'b0; rd = 32'h0; nsel = 0; nen = 0; stable_ok = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge PCLK);
        if (!cmd_ready) to = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d; cmd_write = ~wr;
        h = cyc;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                lat = cyc - h; err = rsp_err; rd = rsp_rdata;
                if (PSELx || PENABLE) stable_ok = 1'b0;
                break;
            end
            nsel += int'(PSELx);
            nen  += int'(PENABLE);
            if (PADDR !== a || PWRITE !== wr || (wr && PWDATA !== d)) stable_ok = 1'b0;
            @(negedge PCLK);
        end
        if (lat < 0) to = 1'b1;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          w;
        bit          tied;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vt[9];
        int lat, nsel, nen, h0, r1, r2, nrsp;
        bit err, stable_ok, to;
        logic [31:0] rd, rd1, rd2;
        logic e1;

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("reset PSELx", 32'(PSELx), 0);
        chk("reset PENABLE", 32'(PENABLE), 0);
        chk("reset PADDR", 32'(PADDR), 0);
        chk("reset PWDATA", PWDATA, 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset cmd_ready", 32'(cmd_ready), 1);
        PRESET = 1'b0;

        vt[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 0,  1'b1, 1'b0, 32'h0,        2};
        vt[1] = '{1'b1, 16'h0080, 32'h12345678, 0,  1'b0, 1'b0, 32'h0,        2};
        vt[2] = '{1'b0, 16'h0080, 32'h0,        2,  1'b0, 1'b0, 32'h12345678, 4};
        vt[3] = '{1'b0, 16'h0040, 32'h0,        1,  1'b0, 1'b0, 32'hDEADBEEF, 3};
        vt[4] = '{1'b0, 16'h0090, 32'h0,        -1, 1'b0, 1'b1, 32'h0,        TO + 1};
        vt[5] = '{1'b1, 16'h00C4, 32'hA5A5A5A5, 3,  1'b0, 1'b0, 32'h0,        5};
        vt[6] = '{1'b0, 16'h00C4, 32'h0,        15, 1'b0, 1'b0, 32'hA5A5A5A5, TO + 1};
        vt[7] = '{1'b1, 16'h00C4, 32'h0,        16, 1'b0, 1'b1, 32'h0,        TO + 1};
        vt[8] = '{1'b0, 16'h00C4, 32'h0,        0,  1'b1, 1'b0, 32'hA5A5A5A5, 2};

        for (int i = 0; i < 9; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].w, vt[i].tied, lat, err, rd, nsel, nen, stable_ok, to);
            chk($sformatf("vec%0d no_timeout", i), 32'(to), 0);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d rsp_err", i), 32'(err), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d rsp_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d psel_cycles", i), 32'(nsel), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d penable_cycles", i), 32'(nen), 32'(vt[i].exp_lat - 1));
            chk($sformatf("vec%0d bus_stable", i), 32'(stable_ok), 1);
        end
        ready_tied = 1'b0;

        // Reset during a wait state: silent abort, then a normal transfer.
        wait_n = -1;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("midrst in_access", 32'(PENABLE), 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("midrst PSELx", 32'(PSELx), 0);
        chk("midrst PENABLE", 32'(PENABLE), 0);
        chk("midrst PADDR", 32'(PADDR), 0);
        chk("midrst rsp_valid", 32'(rsp_valid), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst cmd_ready", 32'(cmd_ready), 1);
        nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            nrsp += int'(rsp_valid);
            @(negedge PCLK);
        end
        chk("midrst no_rsp", 32'(nrsp), 0);
        xfer(1'b0, 16'h0040, 32'h0, 1, 1'b0, lat, err, rd, nsel, nen, stable_ok, to);
        chk("postrst latency", 32'(lat), 3);
        chk("postrst rdata", rd, 32'hDEADBEEF);

        // Back-to-back write then read with cmd_valid held throughout.
        wait_n = 0;
        hs_log.delete();
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h03C0; cmd_wdata = 32'h0BADF00D;
        for (int i = 0; i < 10 && hs_log.size() < 1; i++) @(negedge PCLK);
        cmd_write = 1'b0; cmd_wdata = 32'h0;
        h0 = cyc; r1 = -1; r2 = -1; rd1 = '1; rd2 = 32'h0; e1 = 1'b1; nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            if (hs_log.size() >= 2) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (nrsp == 0) begin r1 = cyc; rd1 = rsp_rdata; e1 = rsp_err; end
                else begin r2 = cyc; rd2 = rsp_rdata; end
                nrsp++;
            end
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        chk("e2e rsp_count", 32'(nrsp), 2);
        chk("e2e handshakes", 32'(hs_log.size()), 2);
        chk("e2e write_latency", 32'(r1 - h0), 2);
        chk("e2e write_rsp", {rd1[30:0], e1}, 32'h0);
        if (hs_log.size() >= 2) chk("e2e read_accept_edge", 32'(hs_log[1]), 32'(r1 + 1));
        chk("e2e read_latency", 32'(r2 - r1), 3);
        chk("e2e read_data", rd2, 32'h0BADF00D);

        // Randomized transfers vs reference: latency 2+w when the slave answers within the limit, else abort.
        for (int n = 0; n < 30; n++) begin
            bit          rw;
            int          w, e_lat;
            bit          e_err;
            logic [15:0] a;
            logic [31:0] d, e_rd;
            rw = 1'($urandom_range(0, 1));
            a  = 16'h0100 + 16'($urandom_range(0, 7) * 4);
            d  = $urandom;
            w  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 18));
            e_err = !(w >= 0 && w <= TO - 1);
            e_lat = e_err ? TO + 1 : 2 + w;
            e_rd  = (rw || e_err) ? 32'h0 : ref_mem[a[9:2]];
            if (rw && !e_err) ref_mem[a[9:2]] = d;
            xfer(rw, a, d, w, 1'b0, lat, err, rd, nsel, nen, stable_ok, to);
            chk($sformatf("rnd%0d latency", n), 32'(lat), 32'(e_lat));
            chk($sformatf("rnd%0d rsp_err", n), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d rsp_rdata", n), rd, e_rd);
            chk($sformatf("rnd%0d penable_cycles", n), 32'(nen), 32'(e_lat - 1));
            chk($sformatf("rnd%0d bus_stable", n), 32'(stable_ok), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
